keypad_key_detector: RTL and testbench

Downstream consumer of the column shift register in the matrix-keypad path. It samples the 4 keypad row lines while the one-hot column drive rotates, and assembles a 16-key snapshot per 4-column scan frame. It rejects multi-key (ghosting) frames, debounces press and release over a programmable number of consecutive frames, and presents a registered 4-bit key code with single-cycle press and release strobes.

---
 rtl/keypad_key_detector.sv | 189 ++++++++++++++++++
 tb/tb_keypad_key_detector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_detector.sv
// Matrix-keypad key detector: assembles a 16-key snapshot per column scan frame,
// rejects ghosting frames and debounces press/release into registered strobes.
module keypad_key_detector #(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [1:0] column_index,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  localparam int unsigned ROWS  = 4;
  localparam int unsigned KEYS  = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ONE_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic [ROWS-1:0]  s1;
  logic [ROWS-1:0]  s2;
  logic [1:0]       c1;
  logic [1:0]       c2;
  logic [KEYS-1:0]  snapshot;

  logic [KEYS-1:0]  frame;
  logic             eof;
  logic [ONE_W-1:0] ones;
  logic [3:0]       hit_idx;
  logic [3:0]       frame_code;
  logic             is_single;
  logic             cand_hit;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       cand;
  logic [3:0]       next_cand;

  logic             press_accept;
  logic             release_accept;
  logic [3:0]       next_code;
  logic             next_valid;
  logic             next_release;
  logic             next_held;

  // Row synchronizer with matching column-index delay; snapshot stored column-major.
  always_ff @(posedge slow_clk) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      c1       <= '0;
      c2       <= '0;
      snapshot <= '0;
    end else begin
      s1                <= row_in;
      s2                <= s1;
      c1                <= column_index;
      c2                <= c1;
      snapshot[4*c2 +: 4] <= s2;
    end
  end

  // The last column's sample is still in s2 when the frame is evaluated.
  always_comb begin
    frame = snapshot;
    if (c2 == 2'd3) begin
      frame[15:12] = s2;
    end
  end

  assign eof = (c2 == 2'd3);

  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (frame[i]) begin
        ones    = ones + ONE_W'(1);
        hit_idx = 4'(i);
      end
    end
  end

  // Snapshot bit index is col*4+row; key code is row*4+col.
  assign is_single  = (ones == ONE_W'(1));
  assign frame_code = {hit_idx[1:0], hit_idx[3:2]};
  assign cand_hit   = frame[{cand[1:0], cand[3:2]}];
  assign cnt_inc    = cnt + CNT_W'(1);

  always_ff @(posedge slow_clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      cand  <= next_cand;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_cand  = cand;
    if (eof) begin
      case (state)
        IDLE: begin
          if (is_single) begin
            next_state = DB_PRESS;
            next_cand  = frame_code;
            next_cnt   = CNT_W'(1);
          end
        end
        DB_PRESS: begin
          if (is_single && (frame_code == cand)) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
              next_state = PRESSED;
              next_cnt   = '0;
            end else begin
              next_cnt = cnt_inc;
            end
          end else begin
            next_state = IDLE;
            next_cnt   = '0;
          end
        end
        PRESSED: begin
          if (!cand_hit) begin
            next_state = DB_RELEASE;
            next_cnt   = CNT_W'(1);
          end
        end
        DB_RELEASE: begin
          if (cand_hit) begin
            next_state = PRESSED;
            next_cnt   = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
            next_state = IDLE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt_inc;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_accept   = eof && (state == DB_PRESS) && is_single &&
                     (frame_code == cand) && (cnt_inc == CNT_W'(DEBOUNCE_FRAMES));
    release_accept = eof && (state == DB_RELEASE) && !cand_hit &&
                     (cnt_inc == CNT_W'(DEBOUNCE_FRAMES));
    next_code      = press_accept ? cand : key_code;
    next_valid     = press_accept;
    next_release   = release_accept;
    next_held      = press_accept | (key_held & ~release_accept);
  end

  always_ff @(posedge slow_clk) begin
    if (!rst) begin
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_code    <= next_code;
      key_valid   <= next_valid;
      key_release <= next_release;
      key_held    <= next_held;
    end
  end

endmodule

// File: tb/tb_keypad_key_detector.sv
// Bench for keypad_key_detector: two instances (4- and 2-frame debounce) driven by a
// rotating column scan and a key mask, checked every cycle against a frame-level model.
module tb_keypad_key_detector;

  localparam int NI = 2;
  localparam int DEB [NI] = '{4, 2};

  logic       slow_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] column_index = 2'd0;
  logic [3:0] row_in = 4'd0;
  logic [3:0] key_code [NI];
  logic       key_valid [NI];
  logic       key_release [NI];
  logic       key_held [NI];

  keypad_key_detector #(.DEBOUNCE_FRAMES(4)) u_deb4 (
    .slow_clk(slow_clk), .rst(rst), .column_index(column_index), .row_in(row_in),
    .key_code(key_code[0]), .key_valid(key_valid[0]), .key_release(key_release[0]),
    .key_held(key_held[0]));

  keypad_key_detector #(.DEBOUNCE_FRAMES(2)) u_deb2 (
    .slow_clk(slow_clk), .rst(rst), .column_index(column_index), .row_in(row_in),
    .key_code(key_code[1]), .key_valid(key_valid[1]), .key_release(key_release[1]),
    .key_held(key_held[1]));

  always #5 slow_clk = ~slow_clk;

  int total = 0;
  int bad = 0;
  int vcount [NI] = '{0, 0};
  int rcount [NI] = '{0, 0};
  bit started = 0;

  logic [15:0] mask = 16'd0;
  int col = 0;

  // Model state: input pipeline, per-column row samples, per-instance debounce.
  logic [3:0] m_s1, m_s2;
  int         m_c1, m_c2;
  logic [3:0] m_nib [4];
  bit         held [NI];
  int         run [NI];
  int         cand [NI];
  int         exp_code [NI];
  bit         exp_valid [NI];
  bit         exp_rel [NI];
  logic [15:0] fr;
  int          n_set;
  int          hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  always @(posedge slow_clk) begin
    if (!rst) begin
      started = 1;
      m_s1 = 0; m_s2 = 0; m_c1 = 0; m_c2 = 0;
      for (int c = 0; c < 4; c++) m_nib[c] = 0;
      for (int i = 0; i < NI; i++) begin
        held[i] = 0; run[i] = 0; cand[i] = 0;
        exp_code[i] = 0; exp_valid[i] = 0; exp_rel[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        exp_valid[i] = 0;
        exp_rel[i] = 0;
      end
      if (m_c2 == 3) begin
        // Frame indexed directly by key code row*4+col.
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            fr[r*4+c] = (c == 3) ? m_s2[r] : m_nib[c][r];
        n_set = $countones(fr);
        hit = 0;
        for (int k = 0; k < 16; k++) if (fr[k]) hit = k;
        for (int i = 0; i < NI; i++) begin
          if (!held[i]) begin
            if (run[i] == 0) begin
              if (n_set == 1) begin cand[i] = hit; run[i] = 1; end
            end else if (n_set == 1 && hit == cand[i]) begin
              run[i]++;
              if (run[i] == DEB[i]) begin
                held[i] = 1; run[i] = 0; exp_code[i] = cand[i]; exp_valid[i] = 1;
              end
            end else begin
              run[i] = 0;
            end
          end else begin
            if (!fr[cand[i]]) begin
              run[i]++;
              if (run[i] == DEB[i]) begin
                held[i] = 0; run[i] = 0; exp_rel[i] = 1;
              end
            end else begin
              run[i] = 0;
            end
          end
        end
      end
      m_nib[m_c2] = m_s2;
      m_s2 = m_s1; m_c2 = m_c1;
      m_s1 = row_in; m_c1 = int'(column_index);
    end
  end

  always @(negedge slow_clk) begin
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("key_code%0d", i), 32'(key_code[i]), 32'(exp_code[i]));
        chk($sformatf("key_valid%0d", i), 32'(key_valid[i]), 32'(exp_valid[i]));
        chk($sformatf("key_release%0d", i), 32'(key_release[i]), 32'(exp_rel[i]));
        chk($sformatf("key_held%0d", i), 32'(key_held[i]), 32'(held[i]));
        vcount[i] += int'(key_valid[i]);
        rcount[i] += int'(key_release[i]);
      end
    end
  end

  // Advance the column scan; row lines reflect the pressed-key mask for the driven column.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge slow_clk);
      col = (col + 1) % 4;
      column_index = 2'(col);
      for (int r = 0; r < 4; r++) row_in[r] = mask[r*4+col];
    end
  endtask

  task automatic align();
    while (col != 3) step(1);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b0;
    step(n);
    rst = 1'b1;
  endtask

  int v0, v1, r0, k1, k2, sel, dur;

  initial begin
    step(3);
    chk("reset_code", 32'(key_code[0]), 32'd0);
    chk("reset_held", 32'(key_held[0]), 32'd0);
    chk("reset_valid", 32'(key_valid[0]), 32'd0);
    rst = 1'b1;

    // Clean press of key 9 (row 2, column 1).
    v0 = vcount[0];
    mask = 16'd1 << 9;
    step(28);
    chk("press9_strobes", 32'(vcount[0] - v0), 32'd1);
    chk("press9_code", 32'(key_code[0]), 32'd9);
    chk("press9_held", 32'(key_held[0]), 32'd1);
    step(40);
    chk("hold9_no_retrigger", 32'(vcount[0] - v0), 32'd1);

    r0 = rcount[0];
    mask = 16'd0;
    step(28);
    chk("release9_strobes", 32'(rcount[0] - r0), 32'd1);
    chk("release9_held", 32'(key_held[0]), 32'd0);
    chk("release9_code", 32'(key_code[0]), 32'd9);

    // Bounce: key 9 alternates on and off each frame.
    v0 = vcount[0];
    align();
    for (int f = 0; f < 10; f++) begin
      mask = (f % 2 == 0) ? (16'd1 << 9) : 16'd0;
      step(4);
    end
    mask = 16'd0;
    step(12);
    chk("bounce_no_valid", 32'(vcount[0] - v0), 32'd0);
    chk("bounce_held", 32'(key_held[0]), 32'd0);

    // Ghosting: keys 0 and 5 together, then key 5 dropped.
    v0 = vcount[0];
    align();
    mask = 16'h0021;
    step(32);
    chk("ghost_no_valid", 32'(vcount[0] - v0), 32'd0);
    mask = 16'h0001;
    step(28);
    chk("ghost_drop_valid", 32'(vcount[0] - v0), 32'd1);
    chk("ghost_drop_code", 32'(key_code[0]), 32'd0);
    mask = 16'd0;
    step(28);

    // Key 15 with a two-frame release glitch, then a real release.
    mask = 16'd1 << 15;
    step(28);
    chk("press15_code", 32'(key_code[0]), 32'd15);
    r0 = rcount[0];
    align();
    mask = 16'd0;
    step(8);
    mask = 16'd1 << 15;
    step(16);
    chk("glitch_no_release", 32'(rcount[0] - r0), 32'd0);
    chk("glitch_held", 32'(key_held[0]), 32'd1);
    mask = 16'd0;
    step(28);
    chk("release15_strobes", 32'(rcount[0] - r0), 32'd1);
    chk("release15_code", 32'(key_code[0]), 32'd15);

    // Reset during press debounce, then during a held key.
    align();
    mask = 16'd1 << 9;
    step(10);
    v0 = vcount[0];
    reset_pulse(1);
    chk("rst_dbp_code", 32'(key_code[0]), 32'd0);
    chk("rst_dbp_held", 32'(key_held[0]), 32'd0);
    step(8);
    chk("rst_dbp_redebounce", 32'(vcount[0] - v0), 32'd0);
    step(28);
    chk("rst_dbp_valid", 32'(vcount[0] - v0), 32'd1);
    r0 = rcount[0];
    reset_pulse(1);
    chk("rst_pressed_held", 32'(key_held[0]), 32'd0);
    chk("rst_pressed_code", 32'(key_code[0]), 32'd0);
    mask = 16'd0;
    step(28);
    chk("rst_pressed_no_release", 32'(rcount[0] - r0), 32'd0);

    // Two-frame debounce instance: key 6 (row 1, column 2).
    reset_pulse(2);
    v1 = vcount[1];
    mask = 16'd1 << 6;
    step(16);
    chk("deb2_press6_valid", 32'(vcount[1] - v1), 32'd1);
    chk("deb2_press6_code", 32'(key_code[1]), 32'd6);
    mask = 16'd0;
    step(20);

    // Randomized key activity with occasional resets.
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 19);
      dur = $urandom_range(1, 32);
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      if (sel < 5) mask = 16'd0;
      else if (sel < 13) mask = 16'd1 << k1;
      else if (sel < 17) mask = (16'd1 << k1) | (16'd1 << k2);
      else if (sel < 19) mask = 16'($urandom);
      else begin
        reset_pulse($urandom_range(1, 3));
        continue;
      end
      step(dur);
    end
    mask = 16'd0;
    step(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
